// File: rtl/comparador_decodificador_param.sv
// Registered unsigned comparator plus selector-to-one-hot decoder with valid/ready handshake
// and a built-in exhaustive sweep that counts equal results for lab self-check.
module comparador_decodificador_param #(
  parameter int N_BITS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_BITS-1:0]      in_a,
  input  logic [N_BITS-1:0]      in_b,
  input  logic [N_BITS-1:0]      in_sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   eq,
  output logic                   gt,
  output logic                   lt,
  output logic [2**N_BITS-1:0]   onehot,
  output logic                   busy,
  output logic                   done,
  output logic [N_BITS:0]        eq_count
);

  localparam int OH = 2**N_BITS;
  localparam int CW = 2*N_BITS;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t              stateReg;
  logic [CW-1:0]       sweepCnt;
  logic                inReadyInt;
  logic                srcValid;
  logic                load;
  logic                xfer;
  logic [N_BITS-1:0]   opA;
  logic [N_BITS-1:0]   opB;
  logic [N_BITS-1:0]   opSel;

  // start wins over in_valid in IDLE, so an external operand is never taken in a start cycle
  always_comb begin
    inReadyInt = !out_valid || out_ready;
    xfer       = out_valid && out_ready;
    srcValid   = 1'b0;
    opA        = in_a;
    opB        = in_b;
    opSel      = in_sel;
    if (stateReg == IDLE) begin
      srcValid = in_valid && !start;
    end else if (stateReg == SWEEP) begin
      srcValid = 1'b1;
      opA      = sweepCnt[CW-1:N_BITS];
      opB      = sweepCnt[N_BITS-1:0];
      opSel    = sweepCnt[CW-1:N_BITS];
    end
    load     = srcValid && inReadyInt;
    in_ready = (stateReg == IDLE) && inReadyInt && !start;
    busy     = (stateReg == SWEEP) || (stateReg == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg  <= IDLE;
      sweepCnt  <= '0;
      out_valid <= 1'b0;
      eq        <= 1'b0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      onehot    <= '0;
      done      <= 1'b0;
      eq_count  <= '0;
    end else begin
      done <= 1'b0;

      if (load) begin
        out_valid <= 1'b1;
        eq        <= (opA == opB);
        gt        <= (opA > opB);
        lt        <= (opA < opB);
        onehot    <= {{(OH-1){1'b0}}, 1'b1} << opSel;
      end else if (xfer) begin
        out_valid <= 1'b0;
        eq        <= 1'b0;
        gt        <= 1'b0;
        lt        <= 1'b0;
        onehot    <= '0;
      end

      if (xfer && eq && busy && (eq_count != (N_BITS+1)'(OH)))
        eq_count <= eq_count + 1'b1;

      case (stateReg)
        IDLE: begin
          if (start) begin
            sweepCnt <= '0;
            eq_count <= '0;
            stateReg <= SWEEP;
          end
        end
        SWEEP: begin
          if (load) begin
            sweepCnt <= sweepCnt + 1'b1;
            if (sweepCnt == '1)
              stateReg <= DRAIN;
          end
        end
        DRAIN: begin
          if (xfer) begin
            stateReg <= DONE;
            done     <= 1'b1;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comparador_decodificador_param.sv
// Directed bench for comparador_decodificador_param (N_BITS=3): external path, backpressure,
// sweeps with steady and toggling ready, start/in_valid collision and mid-sweep reset.
module tb_comparador_decodificador_param;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] in_sel;
  logic         out_valid;
  logic         out_ready;
  logic         eq;
  logic         gt;
  logic         lt;
  logic [7:0]   onehot;
  logic         busy;
  logic         done;
  logic [N:0]   eq_count;

  int vectors = 0;
  int miscompares = 0;
  int nXfer;
  int nBusy;
  int nDone;

  always #5 clk = ~clk;

  comparador_decodificador_param #(.N_BITS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .eq(eq), .gt(gt), .lt(lt), .onehot(onehot),
    .busy(busy), .done(done), .eq_count(eq_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sweep transfer i carries a = i[5:3], b = i[2:0], sel = a
  task automatic chkResult(input int i);
    logic [2:0] a;
    logic [2:0] b;
    logic [31:0] expFlags;
    a = i[5:3];
    b = i[2:0];
    expFlags = {29'd0, (a == b), (a > b), (a < b)};
    chk($sformatf("sweep_flags[%0d]", i), {29'd0, eq, gt, lt}, expFlags);
    chk($sformatf("sweep_onehot[%0d]", i), {24'd0, onehot}, 32'd1 << a);
  endtask

  task automatic runSweep(input bit toggle, input int abortAt,
                          output int xf, output int bz, output int dn);
    xf = 0; bz = 0; dn = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (toggle) out_ready = c[0];
      if (busy) bz++;
      if (done) dn++;
      if (out_valid && out_ready) begin
        chkResult(xf);
        xf++;
      end
      if (done || xf == abortAt) break;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_flags", {29'd0, eq, gt, lt}, 32'd0);
    chk("rst_onehot", 32'(onehot), 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_eq_count", 32'(eq_count), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: a=5 > b=3, sel=5
    in_a = 3'd5; in_b = 3'd3; in_sel = 3'd5; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_flags", {29'd0, eq, gt, lt}, 32'b010);
    chk("t1_onehot", 32'(onehot), 32'h20);

    // 2: backpressure holds the pending result, then the new one follows exactly once
    out_ready = 1'b0; in_a = 3'd2; in_b = 3'd6; in_sel = 3'd2;
    #1;
    chk("t2_in_ready_stall", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("t2_hold_valid", 32'(out_valid), 32'd1);
    chk("t2_hold_flags", {29'd0, eq, gt, lt}, 32'b010);
    chk("t2_hold_onehot", 32'(onehot), 32'h20);
    out_ready = 1'b1;
    #1;
    chk("t2_in_ready_go", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t2_new_flags", {29'd0, eq, gt, lt}, 32'b001);
    chk("t2_new_onehot", 32'(onehot), 32'h04);
    @(posedge clk); #1;
    chk("t2_drained_valid", 32'(out_valid), 32'd0);
    chk("t2_drained_onehot", 32'(onehot), 32'd0);

    // 3: sweep with steady ready
    runSweep(1'b0, -1, nXfer, nBusy, nDone);
    chk("t3_transfers", 32'(nXfer), 32'd64);
    chk("t3_busy_cycles", 32'(nBusy), 32'd65);
    chk("t3_done_pulses", 32'(nDone), 32'd1);
    chk("t3_eq_count", 32'(eq_count), 32'd8);
    @(posedge clk); #1;
    chk("t3_done_cleared", {30'd0, busy, done}, 32'd0);
    chk("t3_idle_ready", 32'(in_ready), 32'd1);

    // 4: sweep with ready toggling every cycle
    runSweep(1'b1, -1, nXfer, nBusy, nDone);
    chk("t4_transfers", 32'(nXfer), 32'd64);
    chk("t4_done_pulses", 32'(nDone), 32'd1);
    chk("t4_eq_count", 32'(eq_count), 32'd8);
    @(posedge clk); #1;

    // 5: start and in_valid together; start wins
    in_a = 3'd1; in_b = 3'd1; in_sel = 3'd7; in_valid = 1'b1; start = 1'b1;
    #1;
    chk("t5_in_ready", 32'(in_ready), 32'd0);
    runSweep(1'b0, -1, nXfer, nBusy, nDone);
    in_valid = 1'b0;
    chk("t5_transfers", 32'(nXfer), 32'd64);
    chk("t5_done_pulses", 32'(nDone), 32'd1);
    chk("t5_eq_count", 32'(eq_count), 32'd8);
    @(posedge clk); #1;

    // 6: reset at transfer 20, then a clean sweep
    runSweep(1'b0, 20, nXfer, nBusy, nDone);
    chk("t6_abort_point", 32'(nXfer), 32'd20);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_flags", {29'd0, eq, gt, lt}, 32'd0);
    chk("t6_rst_onehot", 32'(onehot), 32'd0);
    chk("t6_rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("t6_rst_eq_count", 32'(eq_count), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_no_done", 32'(done), 32'd0);
    runSweep(1'b0, -1, nXfer, nBusy, nDone);
    chk("t6_transfers", 32'(nXfer), 32'd64);
    chk("t6_done_pulses", 32'(nDone), 32'd1);
    chk("t6_eq_count", 32'(eq_count), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
